// File: rtl/branch_resolve_ctrl_pkg.sv
// branch_ctrl_pkg: shared types and constants for the branch resolution controller
package branch_ctrl_pkg;
  localparam int XLEN = 32;
  typedef enum logic [1:0] {IDLE, EVAL, FLUSH} stateT;
  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;
  function automatic logic isIllegal(input logic [2:0] funct3);
    return funct3[2:1] == 2'b01;
  endfunction
endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// branch_resolve_ctrl_if: request/response bundle between pipeline and branch controller
interface branch_resolve_ctrl_if;
  import branch_ctrl_pkg::*;
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_rs1;
  logic [XLEN-1:0] req_rs2;
  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] req_imm;
  logic            req_pred_taken;
  logic            kill;
  logic            resp_valid;
  logic            resp_taken;
  logic            resp_mispredict;
  logic            resp_illegal;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            flush;
  modport master (
    output req_valid, req_funct3, req_rs1, req_rs2, req_pc, req_imm, req_pred_taken, kill,
    input  req_ready, resp_valid, resp_taken, resp_mispredict, resp_illegal,
           redirect_valid, redirect_pc, flush
  );
  modport slave (
    input  req_valid, req_funct3, req_rs1, req_rs2, req_pc, req_imm, req_pred_taken, kill,
    output req_ready, resp_valid, resp_taken, resp_mispredict, resp_illegal,
           redirect_valid, redirect_pc, flush
  );
endinterface

// File: rtl/branch_resolve_ctrl_cond.sv
// br_cond_eval: funct3 decode to taken/illegal and comparator mode; br_comp: the branch comparator
module br_comp
  import branch_ctrl_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            brUn,
  output logic            brEq,
  output logic            brLt
);
  assign brEq = a == b;
  assign brLt = brUn ? a < b : $signed(a) < $signed(b);
endmodule

module br_cond_eval
  import branch_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       brEq,
  input  logic       brLt,
  output logic       taken,
  output logic       illegal,
  output logic       brUn
);
  logic rawCond;
  assign brUn = funct3[1];
  assign illegal = isIllegal(funct3);
  // funct3[0] inverts the base condition; funct3[2] selects lt over eq
  assign rawCond = (funct3[2] ? brLt : brEq) ^ funct3[0];
  assign taken = rawCond && !illegal;
endmodule

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: resolves one RV32I branch, reports mispredicts, drives redirect and flush
module branch_resolve_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input logic                 clk,
  input logic                 reset,
  branch_resolve_ctrl_if.slave bus
);
  stateT           state;
  logic [3:0]      flushCnt;
  logic [2:0]      capFunct3;
  logic [XLEN-1:0] capRs1, capRs2, capPc, capImm;
  logic            capPred;
  logic            brEq, brLt, brUn, condTaken, condIllegal, isMispredict, handshake;
  logic [XLEN-1:0] nextPc;
  br_comp u_comp (.a(capRs1), .b(capRs2), .brUn(brUn), .brEq(brEq), .brLt(brLt));
  br_cond_eval u_cond (
    .funct3(capFunct3), .brEq(brEq), .brLt(brLt),
    .taken(condTaken), .illegal(condIllegal), .brUn(brUn)
  );
  assign bus.req_ready = state == IDLE && !bus.kill && !reset;
  assign handshake = bus.req_valid && bus.req_ready;
  assign isMispredict = !condIllegal && (condTaken ^ capPred);
  assign nextPc = condTaken ? capPc + capImm : capPc + XLEN'(4);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      flushCnt <= '0;
      capFunct3 <= '0;
      capRs1 <= '0;
      capRs2 <= '0;
      capPc <= '0;
      capImm <= '0;
      capPred <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_taken <= 1'b0;
      bus.resp_mispredict <= 1'b0;
      bus.resp_illegal <= 1'b0;
      bus.redirect_valid <= 1'b0;
      bus.redirect_pc <= '0;
      bus.flush <= 1'b0;
    end else begin
      bus.resp_valid <= 1'b0;
      bus.redirect_valid <= 1'b0;
      case (state)
        IDLE: if (handshake) begin
          capFunct3 <= bus.req_funct3;
          capRs1 <= bus.req_rs1;
          capRs2 <= bus.req_rs2;
          capPc <= bus.req_pc;
          capImm <= bus.req_imm;
          capPred <= bus.req_pred_taken;
          state <= EVAL;
        end
        EVAL: if (bus.kill) state <= IDLE;
        else begin
          bus.resp_valid <= 1'b1;
          bus.resp_taken <= condTaken;
          bus.resp_mispredict <= isMispredict;
          bus.resp_illegal <= condIllegal;
          bus.redirect_pc <= nextPc;
          bus.redirect_valid <= isMispredict;
          bus.flush <= isMispredict;
          flushCnt <= 4'(FLUSH_CYCLES - 1);
          state <= isMispredict ? FLUSH : IDLE;
        end
        FLUSH: if (flushCnt == 4'd0) begin
          bus.flush <= 1'b0;
          state <= IDLE;
        end else flushCnt <= flushCnt - 4'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb_branch_resolve_ctrl: directed self-checking bench for branch_resolve_ctrl
module tb_branch_resolve_ctrl;
  import branch_ctrl_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  branch_resolve_ctrl_if bus();
  branch_resolve_ctrl #(.FLUSH_CYCLES(2)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  // {resp_valid, taken, mispredict, illegal, redirect_valid, flush, req_ready}
  wire [6:0] st = {bus.resp_valid, bus.resp_taken, bus.resp_mispredict, bus.resp_illegal,
                   bus.redirect_valid, bus.flush, bus.req_ready};

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] imm, input logic pred);
    bus.req_funct3 = f3;
    bus.req_rs1 = a;
    bus.req_rs2 = b;
    bus.req_pc = pc;
    bus.req_imm = imm;
    bus.req_pred_taken = pred;
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step();
    step();
    vectors++;
    if (st !== 7'b0000000) begin miscompares++; $display("FAIL reset_st got %b exp %b", st, 7'b0000000); end
    vectors++;
    if (bus.redirect_pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc got %h exp %h", bus.redirect_pc, 32'h0); end
    reset = 1'b0;
    #1;
    vectors++;
    if (st !== 7'b0000001) begin miscompares++; $display("FAIL reset_release got %b exp %b", st, 7'b0000001); end
  endtask

  task automatic test_beq_mispredict;
    drive(BEQ, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0);
    vectors++;
    if (st !== 7'b0000000) begin miscompares++; $display("FAIL beq_eval got %b exp %b", st, 7'b0000000); end
    step();
    vectors++;
    if (st !== 7'b1110110) begin miscompares++; $display("FAIL beq_resp got %b exp %b", st, 7'b1110110); end
    vectors++;
    if (bus.redirect_pc !== 32'h120) begin miscompares++; $display("FAIL beq_pc got %h exp %h", bus.redirect_pc, 32'h120); end
    step();
    vectors++;
    if (st !== 7'b0110010) begin miscompares++; $display("FAIL beq_flush2 got %b exp %b", st, 7'b0110010); end
    vectors++;
    if (bus.redirect_pc !== 32'h120) begin miscompares++; $display("FAIL beq_pc_hold got %h exp %h", bus.redirect_pc, 32'h120); end
    step();
    vectors++;
    if (st !== 7'b0110001) begin miscompares++; $display("FAIL beq_idle got %b exp %b", st, 7'b0110001); end
  endtask

  task automatic test_blt_bltu;
    drive(BLT, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h40, 1'b0);
    vectors++;
    if (st !== 7'b0110000) begin miscompares++; $display("FAIL blt_eval got %b exp %b", st, 7'b0110000); end
    step();
    vectors++;
    if (st !== 7'b1110110) begin miscompares++; $display("FAIL blt_resp got %b exp %b", st, 7'b1110110); end
    vectors++;
    if (bus.redirect_pc !== 32'h240) begin miscompares++; $display("FAIL blt_pc got %h exp %h", bus.redirect_pc, 32'h240); end
    step();
    step();
    vectors++;
    if (st !== 7'b0110001) begin miscompares++; $display("FAIL blt_idle got %b exp %b", st, 7'b0110001); end
    drive(BLTU, 32'hFFFFFFFF, 32'd1, 32'h300, 32'h40, 1'b0);
    step();
    vectors++;
    if (st !== 7'b1000001) begin miscompares++; $display("FAIL bltu_resp got %b exp %b", st, 7'b1000001); end
    vectors++;
    if (bus.redirect_pc !== 32'h304) begin miscompares++; $display("FAIL bltu_pc got %h exp %h", bus.redirect_pc, 32'h304); end
  endtask

  task automatic test_back_to_back_bne;
    drive(BNE, 32'd1, 32'd2, 32'hFFFFFFF0, 32'h20, 1'b1);
    vectors++;
    if (st !== 7'b0000000) begin miscompares++; $display("FAIL bne_eval got %b exp %b", st, 7'b0000000); end
    step();
    vectors++;
    if (st !== 7'b1100001) begin miscompares++; $display("FAIL bne_resp got %b exp %b", st, 7'b1100001); end
    vectors++;
    if (bus.redirect_pc !== 32'h10) begin miscompares++; $display("FAIL bne_pc_wrap got %h exp %h", bus.redirect_pc, 32'h10); end
    step();
    vectors++;
    if (st !== 7'b0100001) begin miscompares++; $display("FAIL bne_noflush got %b exp %b", st, 7'b0100001); end
  endtask

  task automatic test_illegal;
    drive(3'b010, 32'd7, 32'd7, 32'h400, 32'h8, 1'b0);
    vectors++;
    if (st !== 7'b0100000) begin miscompares++; $display("FAIL ill010_eval got %b exp %b", st, 7'b0100000); end
    step();
    vectors++;
    if (st !== 7'b1001001) begin miscompares++; $display("FAIL ill010_resp got %b exp %b", st, 7'b1001001); end
    drive(3'b011, 32'd7, 32'd7, 32'h404, 32'h8, 1'b1);
    step();
    vectors++;
    if (st !== 7'b1001001) begin miscompares++; $display("FAIL ill011_resp got %b exp %b", st, 7'b1001001); end
    step();
    vectors++;
    if (st !== 7'b0001001) begin miscompares++; $display("FAIL ill011_after got %b exp %b", st, 7'b0001001); end
  endtask

  task automatic test_kill;
    drive(BEQ, 32'd5, 32'd5, 32'h600, 32'h10, 1'b0);
    bus.kill = 1'b1;
    step();
    bus.kill = 1'b0;
    #1;
    vectors++;
    if (st !== 7'b0001001) begin miscompares++; $display("FAIL kill_eval got %b exp %b", st, 7'b0001001); end
    step();
    vectors++;
    if (st !== 7'b0001001) begin miscompares++; $display("FAIL kill_eval_late got %b exp %b", st, 7'b0001001); end
    bus.kill = 1'b1;
    bus.req_valid = 1'b1;
    #1;
    vectors++;
    if (st !== 7'b0001000) begin miscompares++; $display("FAIL kill_idle_ready got %b exp %b", st, 7'b0001000); end
    step();
    bus.kill = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    vectors++;
    if (st !== 7'b0001001) begin miscompares++; $display("FAIL kill_idle_nohs got %b exp %b", st, 7'b0001001); end
    step();
    vectors++;
    if (st !== 7'b0001001) begin miscompares++; $display("FAIL kill_idle_noresp got %b exp %b", st, 7'b0001001); end
  endtask

  task automatic test_ge;
    logic [2:0] f3 [2] = '{BGE, BGEU};
    logic [2:0] exp [2] = '{3'b110, 3'b101};
    for (int i = 0; i < 2; i++) begin
      int n = 0;
      drive(f3[i], 32'd1, 32'hFFFFFFFF, 32'h700, 32'h10, 1'b1);
      step();
      vectors++;
      if ({bus.resp_valid, bus.resp_taken, bus.resp_mispredict} !== exp[i]) begin
        miscompares++;
        $display("FAIL ge_%0d got %b exp %b", i, {bus.resp_valid, bus.resp_taken, bus.resp_mispredict}, exp[i]);
      end
      while (bus.req_ready !== 1'b1 && n < 10) begin step(); n++; end
      vectors++;
      if (n >= 10) begin miscompares++; $display("FAIL ge_%0d_ready_timeout got %0d exp <10", i, n); end
    end
  endtask

  task automatic test_reset_in_flush;
    drive(BEQ, 32'd9, 32'd9, 32'h500, 32'h8, 1'b0);
    step();
    vectors++;
    if (st !== 7'b1110110) begin miscompares++; $display("FAIL rf_resp got %b exp %b", st, 7'b1110110); end
    reset = 1'b1;
    step();
    vectors++;
    if (st !== 7'b0000000) begin miscompares++; $display("FAIL rf_cleared got %b exp %b", st, 7'b0000000); end
    vectors++;
    if (bus.redirect_pc !== 32'h0) begin miscompares++; $display("FAIL rf_pc got %h exp %h", bus.redirect_pc, 32'h0); end
    reset = 1'b0;
    step();
    vectors++;
    if (st !== 7'b0000001) begin miscompares++; $display("FAIL rf_ready got %b exp %b", st, 7'b0000001); end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_funct3 = '0;
    bus.req_rs1 = '0;
    bus.req_rs2 = '0;
    bus.req_pc = '0;
    bus.req_imm = '0;
    bus.req_pred_taken = 1'b0;
    bus.kill = 1'b0;
    test_reset();
    test_beq_mispredict();
    test_blt_bltu();
    test_back_to_back_bne();
    test_illegal();
    test_kill();
    test_ge();
    test_reset_in_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/branch_resolve_ctrl.md
BRANCH_RESOLVE_CTRL -- requirements
Module: branch_resolve_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2, number of cycles flush is held after a mispredict (legal range 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  branch request present.
REQ-005 req_ready  output  1  controller can accept a request this cycle.
REQ-006 req_funct3  input  3  RV32I branch funct3.
REQ-007 req_rs1, req_rs2  input  32 each  branch operands.
REQ-008 req_pc  input  32  PC of branch instruction.
REQ-009 req_imm  input  32  sign-extended B-type offset.
REQ-010 req_pred_taken  input  1  front-end prediction.
REQ-011 kill  input  1  pipeline kill from older instruction; cancels in-flight branch.
REQ-012 resp_valid  output  1  one-cycle pulse, resolution result valid.
REQ-013 resp_taken, resp_mispredict, resp_illegal  output  1 each  resolution outcome.
REQ-014 redirect_valid  output  1  one-cycle pulse, fetch must restart at redirect_pc.
REQ-015 redirect_pc  output  32  corrected fetch address.
REQ-016 flush  output  1  younger-instruction squash, held FLUSH_CYCLES cycles.

Function
REQ-017 FSM states SHALL be IDLE, EVAL, FLUSH.
REQ-018 req_ready SHALL be 1 only in IDLE with kill=0 and reset=0; handshake = req_valid & req_ready at rising edge.
REQ-019 On handshake SHALL capture funct3, rs1, rs2, pc, imm, pred_taken and enter EVAL.
REQ-020 EVAL lasts exactly one cycle; comparator driven from captured operands, BrUn = funct3[1].
REQ-021 Condition: 000 eq; 001 !eq; 100 signed lt; 101 !signed lt; 110 unsigned lt; 111 !unsigned lt.
REQ-022 funct3 010/011 SHALL give resp_illegal=1, resp_taken=0, resp_mispredict=0, no redirect, no flush.
REQ-023 resp_mispredict = resp_taken XOR pred_taken (legal funct3 only).
REQ-024 redirect_pc = taken ? pc+imm : pc+4, modulo 2^32 (wrap, no overflow flag).
REQ-025 Outputs registered at the EVAL-exit edge: handshake at edge T, resp_valid high in cycle T+2 only.
REQ-026 No mispredict: EVAL -> IDLE; req_ready=1 in the resp_valid cycle (back-to-back throughput one branch per 2 cycles).
REQ-027 Mispredict: EVAL -> FLUSH; redirect_valid pulses with resp_valid; flush=1 for exactly FLUSH_CYCLES cycles starting that cycle; req_ready=0 throughout; then IDLE.
REQ-028 kill=1 in EVAL SHALL discard the branch: no resp_valid, no redirect, no flush, next state IDLE.
REQ-029 kill=1 in IDLE blocks acceptance even if req_valid=1; kill ignored in FLUSH.
REQ-030 resp_taken/mispredict/illegal/redirect_pc SHALL hold last value when resp_valid=0.

Reset
REQ-031 reset=1 at an edge SHALL force IDLE, clear flush counter, and drive all outputs 0 (redirect_pc=32'h0) in the following cycle, regardless of state.
REQ-032 Reset during EVAL or FLUSH SHALL suppress any pending resp_valid, redirect_valid and flush.
REQ-033 req_ready SHALL be 0 while reset=1.

Structure
REQ-034 Package branch_ctrl_pkg SHALL hold the state enum, funct3 constants (BEQ..BGEU) and XLEN=32.
REQ-035 Sub-module br_cond_eval SHALL map funct3, BrEq, BrLt to taken, illegal, BrUn combinationally; existing branch comparator instantiated once.
REQ-036 Flush counter width 4 bits.

Verification
REQ-037 BEQ rs1=rs2=5, pc=0x100, imm=0x20, pred=0 -> cycle T+2 resp_valid, taken=1, mispredict=1, redirect_pc=0x120, flush high 2 cycles, req_ready low 2 cycles.
REQ-038 BLT rs1=0xFFFFFFFF, rs2=1 taken; BLTU same operands not taken, pred=0 -> BLT mispredict=1, BLTU mispredict=0, redirect_pc=pc+4.
REQ-039 BNE rs1=1, rs2=2, pc=0xFFFFFFF0, imm=0x20, pred=1 -> taken=1, mispredict=0, redirect_pc=0x00000010, no flush.
REQ-040 funct3=010 -> resp_illegal=1, taken=0, no redirect/flush.
REQ-041 kill asserted during EVAL -> no resp_valid; kill with req_valid in IDLE -> no handshake.
REQ-042 reset asserted in first flush cycle -> flush=0 and all outputs 0 next cycle, req_ready=1 one cycle after reset deasserts.
